// File: rtl/tdm_demux1to4.sv
// Time-division 1-to-4 demultiplexer: reassembles lane 0..3 interleaved beats into parallel frames.
// Optional lane resynchronisation (in_sync/sync_err) is built when TDM_DEMUX_SYNC_EN is defined.
module tdm_demux1to4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [4*WIDTH-1:0] out_data,
  input  logic               out_ready,
  output logic [1:0]         lane
`ifdef TDM_DEMUX_SYNC_EN
  ,
  input  logic               in_sync,
  output logic               sync_err
`endif
);

  logic [1:0]         lane_q, lane_d;
  logic [WIDTH-1:0]   col_q [3];
  logic [WIDTH-1:0]   col_d [3];
  logic               out_valid_q, out_valid_d;
  logic [4*WIDTH-1:0] out_data_q, out_data_d;
  logic               sync_err_q, sync_err_d;
  logic               sync_w;
  logic               resync;
  logic               accept;

`ifdef TDM_DEMUX_SYNC_EN
  assign sync_w   = in_sync;
  assign sync_err = sync_err_q;
`else
  assign sync_w   = 1'b0;
`endif

  // A sync beat restarts the frame at lane 0, so it can never be the stalling lane 3 beat.
  assign in_ready  = (lane_q != 2'd3) || !out_valid_q || out_ready || sync_w;
  assign accept    = in_valid && in_ready;
  assign resync    = sync_w && (lane_q != 2'd0);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign lane      = lane_q;

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    lane_d      = lane_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sync_err_d  = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (resync) begin
        col_d[0]   = in_data;
        lane_d     = 2'd1;
        sync_err_d = 1'b1;
      end else if (lane_q == 2'd3) begin
        // Lane 3 goes straight into the frame; a load here wins over the drain above.
        out_data_d  = {in_data, col_q[2], col_q[1], col_q[0]};
        out_valid_d = 1'b1;
        lane_d      = 2'd0;
      end else begin
        col_d[lane_q] = in_data;
        lane_d        = lane_q + 2'd1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q      <= 2'd0;
      // NOTE: the collection regs are few and must read as zero after reset, so they are reset too.
      col_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sync_err_q  <= sync_err_d;
    end
  end

endmodule

// File: doc/tdm_demux1to4.md
Name: tdm_demux1to4

Overview:
- Time-division 1-to-4 demultiplexer. It is the receive-side counterpart of our 4:1 select mux.
- Consumes a serial stream of beats that were interleaved lane 0,1,2,3,0,... by a rotating-select mux.
- Reassembles each group of 4 beats into one parallel frame and presents it on a valid/ready output.
- Sits between a serial link/TDM channel and the parallel datapath.

Parameters:
- WIDTH, 1, bits per lane beat (matches the per-input width of the transmit mux).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_data  input  WIDTH  input beat.
- in_ready  output  1  block can accept a beat this cycle.
- out_valid  output  1  assembled frame valid.
- out_data  output  4*WIDTH  frame; lane n at bits [n*WIDTH +: WIDTH], lane 0 in LSBs.
- out_ready  input  1  downstream accepts the frame.
- lane  output  2  lane index the next accepted beat will fill.

Behaviour:
- Reset, sampled on clk rising edge while reset=1:
  - lane=0, out_valid=0, out_data=0, collection regs col0..col2=0.
  - Reset overrides all other activity in that cycle.
- Accept = in_valid && in_ready.
- Lane counter:
  - On accept, the beat goes to lane `lane`, then lane <= lane+1 mod 4 (3 wraps to 0).
  - No accept means no change.
- Beats on lanes 0..2 are written to col0..col2.
- A lane 3 beat is not stored separately: on a lane 3 accept, out_data <= {in_data, col2, col1, col0} and out_valid <= 1 on the same edge.
  - Latency: frame visible on out_valid/out_data 1 cycle after the lane 3 beat is accepted.
- Output hold:
  - While out_valid=1 && out_ready=0, out_data and out_valid are stable.
  - out_valid drops on the edge where out_valid && out_ready, unless a new frame loads on that same edge.
- in_ready (combinational) = (lane != 3) || !out_valid || out_ready.
  - Lanes 0..2 always accept, so the next frame is collected while the previous frame is held.
  - Only the lane 3 beat stalls, and only when the output is occupied and not draining.
- Simultaneous lane 3 accept and output handshake: the new frame loads and out_valid stays 1. Back-to-back frames therefore need no bubble.
- Throughput: 1 beat/cycle sustained when out_ready=1.
- in_data is ignored when in_valid=0. Collection regs change only on accept.
- Reset mid-frame: the partial frame is discarded and the first beat after reset is lane 0. A held output frame is also discarded.
- Registered outputs: out_valid, out_data, lane. in_ready is the only combinational output, and it depends on lane, out_valid and out_ready.

Optional Feature:
- Macro TDM_DEMUX_SYNC_EN.
- Defined: adds ports in_sync (input, 1; marks a beat as lane 0) and sync_err (output, 1, registered, reset 0).
  - On an accept with in_sync=1 and lane!=0:
    - The beat is written to col0 and lane <= 1.
    - The partial frame is discarded, so no out_valid is generated for it.
    - sync_err pulses 1 for exactly one cycle.
  - in_sync=1 with lane=0: normal operation, no error.
  - in_sync without accept: ignored.
  - For the in_ready rule, a sync beat arriving while lane=3 is treated as lane 0, so it is never stalled.
- Not defined: no in_sync/sync_err ports; lane alignment comes purely from the free-running counter.

Test Plan:
- WIDTH=4, out_ready=1, feed beats 0x1,0x2,0x3,0x4 on consecutive cycles -> one cycle after beat 0x4, out_valid=1 and out_data=0x4321; lane returns to 0.
- Continuous 8 beats 0x1..0x8 with out_ready=1 -> frames 0x4321 then 0x8765 on back-to-back valid windows; in_ready stays 1 throughout.
- First frame 0x4321 held with out_ready=0, then feed 0x5,0x6,0x7,0x8 -> 0x5..0x7 accepted; in_ready=0 with lane=3; out_data stays 0x4321. Raise out_ready -> 0x8 accepted the same cycle, and next out_data=0x8765.
- Feed 0xA,0xB, assert reset 1 cycle, then feed 0x1..0x4 -> out_valid=0 after reset and the frame is 0x4321, with no 0xA/0xB content.
- in_valid toggling 1,0,1,0... with data 0x1..0x4 -> same frame 0x4321; lane advances only on valid cycles.
- (TDM_DEMUX_SYNC_EN) Feed 0x9,0xA, then 0x1 with in_sync=1, then 0x2,0x3,0x4 -> sync_err pulses once, no frame for 0x9/0xA, and the next frame is 0x4321.
